// File: rtl/parity_lane_pipe_pkg.sv
// parity_pkg: shared types and the lane-parity helper used by parity_lane_pipe.
package parity_pkg;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_mode_e;

  // Widest beat and lane count the helper can cover; callers zero-extend into these.
  localparam int MAX_DATA_W = 1024;
  localparam int MAX_LANES  = 64;
  localparam int LANE_IDX_W = 6;

  // Folds every data bit into the parity bit of the lane it belongs to, then
  // inverts the whole vector for odd parity. Bits above data_w are ignored.
  function automatic logic [MAX_LANES-1:0] lane_parity(
    input logic [MAX_DATA_W-1:0] data,
    input int                    data_w,
    input int                    lanes,
    input parity_mode_e          mode
  );
    logic [MAX_LANES-1:0]  par;
    logic [LANE_IDX_W-1:0] laneIdx;
    int                    laneW;
    par   = '0;
    laneW = data_w / lanes;
    for (int j = 0; j < MAX_DATA_W; j++) begin
      if (j < data_w) begin
        laneIdx      = LANE_IDX_W'(j / laneW);
        par[laneIdx] = par[laneIdx] ^ data[j];
      end
    end
    if (mode == PAR_ODD) begin
      par = ~par;
    end
    return par;
  endfunction

endpackage

// File: rtl/parity_lane_pipe_if.sv
// parity_lane_pipe_if: input stream, output stream, mode controls and error status
// of the lane parity pipe bundled in one place.
interface parity_lane_pipe_if #(
  parameter int DATA_W    = 32,
  parameter int LANES     = 4,
  parameter int ERR_CNT_W = 16
);

  logic                 odd_mode;
  logic                 check_en;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_data;
  logic [LANES-1:0]     in_parity;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_data;
  logic [LANES-1:0]     out_parity;
  logic [LANES-1:0]     out_err;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 err_sticky;
  logic                 clear_err;

  // Upstream/downstream environment that talks to the pipe.
  modport master (
    output odd_mode, check_en, in_valid, in_data, in_parity, out_ready, clear_err,
    input  in_ready, out_valid, out_data, out_parity, out_err, err_count, err_sticky
  );

  // The parity pipe itself.
  modport slave (
    input  odd_mode, check_en, in_valid, in_data, in_parity, out_ready, clear_err,
    output in_ready, out_valid, out_data, out_parity, out_err, err_count, err_sticky
  );

endinterface

// File: rtl/parity_lane_pipe_stage.sv
// parity_pipe_stage: one valid/ready register slice with a generic payload.
// It accepts a new beat whenever it is empty or its current beat is leaving.
module parity_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Load on advance; payload only changes when a real beat arrives so a stalled beat stays stable.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/parity_lane_pipe.sv
// parity_lane_pipe: two-stage lane parity generator/checker on a valid/ready stream
// with a saturating error-beat counter and sticky error flag.
module parity_lane_pipe
  import parity_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int LANES     = 4,
  parameter int ERR_CNT_W = 16
) (
  input  logic clock,
  input  logic reset,
  parity_lane_pipe_if.slave bus
);

  localparam int S1_W = DATA_W + LANES + 2;
  localparam int S2_W = DATA_W + 2 * LANES;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  if (DATA_W % LANES != 0) begin : g_laneSplitCheck
    $error("parity_lane_pipe: DATA_W must be a multiple of LANES");
  end
  if (DATA_W > MAX_DATA_W || LANES > MAX_LANES) begin : g_maxSizeCheck
    $error("parity_lane_pipe: DATA_W or LANES exceeds the helper limits");
  end

  logic              w_s1InReady;
  logic              w_s1Valid;
  logic [S1_W-1:0]   w_s1Payload;
  logic              w_adv2;
  logic              w_s2Valid;
  logic [S2_W-1:0]   w_s2Payload;
  logic [DATA_W-1:0] w_s1Data;
  logic [LANES-1:0]  w_s1RxParity;
  logic              w_s1Odd;
  logic              w_s1Check;
  parity_mode_e      w_s1Mode;
  logic [LANES-1:0]  w_parity;
  logic [LANES-1:0]  w_err;
  logic              w_errLoad;
  logic [ERR_CNT_W-1:0] r_errCount;
  logic                 r_errSticky;

  parity_pipe_stage #(.W(S1_W)) u_stage1 (
    .clock   (clock),
    .reset   (reset),
    .i_valid (bus.in_valid),
    .o_ready (w_s1InReady),
    .i_data  ({bus.in_data, bus.in_parity, bus.odd_mode, bus.check_en}),
    .o_valid (w_s1Valid),
    .i_ready (w_adv2),
    .o_data  (w_s1Payload)
  );

  assign w_s1Check    = w_s1Payload[0];
  assign w_s1Odd      = w_s1Payload[1];
  assign w_s1RxParity = w_s1Payload[LANES+1:2];
  assign w_s1Data     = w_s1Payload[S1_W-1:LANES+2];
  assign w_s1Mode     = w_s1Odd ? PAR_ODD : PAR_EVEN;

  // Parity and mismatch are computed from the beat sitting in S1 and registered into S2.
  always_comb begin
    w_parity = LANES'(lane_parity(MAX_DATA_W'(w_s1Data), DATA_W, LANES, w_s1Mode));
    w_err    = '0;
    if (w_s1Check) begin
      w_err = w_parity ^ w_s1RxParity;
    end
  end

  parity_pipe_stage #(.W(S2_W)) u_stage2 (
    .clock   (clock),
    .reset   (reset),
    .i_valid (w_s1Valid),
    .o_ready (w_adv2),
    .i_data  ({w_s1Data, w_parity, w_err}),
    .o_valid (w_s2Valid),
    .i_ready (bus.out_ready),
    .o_data  (w_s2Payload)
  );

  // An erroring beat counts exactly once: on the edge it moves from S1 into S2.
  assign w_errLoad = w_s1Valid && w_adv2 && (|w_err);

  // Clear beats a same-cycle error; the counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_errCount  <= '0;
      r_errSticky <= 1'b0;
    end else if (bus.clear_err) begin
      r_errCount  <= '0;
      r_errSticky <= 1'b0;
    end else if (w_errLoad) begin
      r_errSticky <= 1'b1;
      if (r_errCount != CNT_MAX) begin
        r_errCount <= r_errCount + 1'b1;
      end
    end
  end

  assign bus.in_ready   = w_s1InReady && !reset;
  assign bus.out_valid  = w_s2Valid;
  assign bus.out_err    = w_s2Payload[LANES-1:0];
  assign bus.out_parity = w_s2Payload[2*LANES-1:LANES];
  assign bus.out_data   = w_s2Payload[S2_W-1:2*LANES];
  assign bus.err_count  = r_errCount;
  assign bus.err_sticky = r_errSticky;

endmodule
